// File: rtl/i2c_rx_byte_ctrl.sv
// Receive-byte sequencer: synchronizes SCL/SDA, strobes an external SIPO shift
// register once per SCL rise, then runs the ACK/NACK slot and reports completion.
module i2c_rx_byte_ctrl #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst_,
  input  logic                           enable,
  input  logic                           start_rx,
  input  logic                           abort,
  input  logic                           ack_en,
  input  logic                           scl_in,
  input  logic                           sda_in,
  output logic                           sipo_clear,
  output logic                           sipo_load,
  output logic                           sipo_bit,
  output logic                           sda_drive_low,
  output logic                           busy,
  output logic [$clog2(DATA_BITS+1)-1:0] bit_cnt,
  output logic                           byte_done,
  output logic                           ack_sent
);

  localparam int CW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    WAIT_LOW,
    ACK_LOW,
    ACK_HIGH,
    DONE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_hist_q, scl_hist_d;
  logic                   scl_s, sda_s, scl_rise, scl_fall;

  state_t        state_q, state_d;
  logic          capture_q, capture_d;
  logic          capture_bit_q, capture_bit_d;
  logic          sipo_clear_q, sipo_clear_d;
  logic          sipo_load_q, sipo_load_d;
  logic          sipo_bit_q, sipo_bit_d;
  logic          sda_low_q, sda_low_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          ack_sent_q, ack_sent_d;
  logic          ack_flag_q, ack_flag_d;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_hist_d = scl_sync_q[SYNC_STAGES-1];
  end

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_hist_q;
  assign scl_fall = ~scl_s & scl_hist_q;

  // Synchronizers preset high so a reset never looks like bus activity.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    capture_d     = 1'b0;
    capture_bit_d = capture_bit_q;
    sipo_clear_d  = 1'b0;
    sipo_load_d   = 1'b0;
    sipo_bit_d    = sipo_bit_q;
    sda_low_d     = sda_low_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    ack_sent_d    = ack_sent_q;
    ack_flag_d    = ack_flag_q;

    // The sampled bit is held one cycle before it is presented, so the
    // strobe lands SYNC_STAGES+1 cycles after SCL is first sampled high.
    if (capture_q) begin
      sipo_load_d = 1'b1;
      sipo_bit_d  = capture_bit_q;
      cnt_d       = cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start_rx && enable) begin
          state_d      = CLEAR;
          sipo_clear_d = 1'b1;
          cnt_d        = '0;
        end
      end
      CLEAR: state_d = SHIFT;
      SHIFT: begin
        if (scl_rise) begin
          capture_d     = 1'b1;
          capture_bit_d = sda_s;
        end
        if (capture_q && (cnt_d == CW'(DATA_BITS))) state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (scl_fall) begin
          state_d    = ACK_LOW;
          ack_flag_d = ack_en;
          sda_low_d  = ack_en;
        end
      end
      ACK_LOW: begin
        if (scl_rise) state_d = ACK_HIGH;
      end
      ACK_HIGH: begin
        if (scl_fall) begin
          state_d    = DONE;
          sda_low_d  = 1'b0;
          done_d     = 1'b1;
          ack_sent_d = ack_flag_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && (abort || !enable)) begin
      state_d      = IDLE;
      capture_d    = 1'b0;
      sipo_clear_d = 1'b0;
      sipo_load_d  = 1'b0;
      sda_low_d    = 1'b0;
      cnt_d        = cnt_q;
      done_d       = 1'b0;
      ack_sent_d   = ack_sent_q;
    end
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q       <= IDLE;
      capture_q     <= 1'b0;
      capture_bit_q <= 1'b0;
      sipo_clear_q  <= 1'b0;
      sipo_load_q   <= 1'b0;
      sipo_bit_q    <= 1'b0;
      sda_low_q     <= 1'b0;
      busy_q        <= 1'b0;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      ack_sent_q    <= 1'b0;
      ack_flag_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      capture_q     <= capture_d;
      capture_bit_q <= capture_bit_d;
      sipo_clear_q  <= sipo_clear_d;
      sipo_load_q   <= sipo_load_d;
      sipo_bit_q    <= sipo_bit_d;
      sda_low_q     <= sda_low_d;
      busy_q        <= busy_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      ack_sent_q    <= ack_sent_d;
      ack_flag_q    <= ack_flag_d;
    end
  end

  assign sipo_clear    = sipo_clear_q;
  assign sipo_load     = sipo_load_q;
  assign sipo_bit      = sipo_bit_q;
  assign sda_drive_low = sda_low_q;
  assign busy          = busy_q;
  assign bit_cnt       = cnt_q;
  assign byte_done     = done_q;
  assign ack_sent      = ack_sent_q;

endmodule

// File: doc/i2c_rx_byte_ctrl.md
Name: i2c_rx_byte_ctrl

Overview:
Sequencer for the serial-in/parallel-out receive shift register in the I2C slave/master receive path. Synchronizes raw SCL/SDA, detects SCL edges, and drives the shift register's clear/load/serial-bit inputs for one byte of DATA_BITS bits. Then runs the ACK/NACK bit-slot (optional SDA pull-low) and reports byte completion. One byte per start_rx command; the parent protocol FSM issues the next command.

Parameters:
DATA_BITS, 8, number of data bits shifted per byte (range 2..16)
SYNC_STAGES, 2, flip-flop stages in the scl_in/sda_in synchronizers (>=2)

Ports:
clk  input  1  system clock
rst_  input  1  asynchronous active-low reset
enable  input  1  block enable; low forces abort behaviour
start_rx  input  1  single-cycle command: receive one byte
abort  input  1  single-cycle abort (e.g. STOP/repeated START detected upstream)
ack_en  input  1  1 = drive ACK in the 9th slot, 0 = NACK (release SDA); sampled on entry to ACK
scl_in  input  1  raw SCL line
sda_in  input  1  raw SDA line
sipo_clear  output  1  clear strobe to shift register
sipo_load  output  1  shift-enable strobe to shift register
sipo_bit  output  1  serial data bit to shift register, valid while sipo_load=1
sda_drive_low  output  1  1 = open-drain pull SDA low
busy  output  1  high from accepted start_rx until return to IDLE
bit_cnt  output  $clog2(DATA_BITS+1)  number of bits shifted in the current byte
byte_done  output  1  single-cycle pulse, byte plus ACK slot complete
ack_sent  output  1  ack_en value used for the last completed byte; held until the next byte_done

Behaviour:
- Interface: one clock (clk); reset rst_ is asynchronous, active-low. All outputs are registered.
- Reset: all outputs 0, state IDLE, synchronizers loaded with 1 (bus idle). Assertion mid-byte releases SDA immediately and emits no byte_done.
- Synchronizers: scl_in and sda_in each pass through SYNC_STAGES flops, plus one history flop on SCL. scl_rise and scl_fall are combinational decodes of the synchronized SCL and its history flop.
- States: IDLE, CLEAR, SHIFT, WAIT_LOW, ACK_LOW, ACK_HIGH, DONE.
- IDLE: start_rx=1 and enable=1 -> CLEAR. start_rx is ignored while busy.
- CLEAR: sipo_clear=1 for exactly 1 cycle; bit_cnt<=0; -> SHIFT.
- SHIFT: on scl_rise, sipo_load=1 for exactly 1 cycle with sipo_bit = synchronized SDA, and bit_cnt increments. When bit_cnt reaches DATA_BITS -> WAIT_LOW.
- Strobe latency: sipo_load rises SYNC_STAGES+1 clk cycles after the first clk edge that samples scl_in high.
- WAIT_LOW: on scl_fall -> ACK_LOW; latch ack_en into an internal flag. sda_drive_low <= ack_en, registered on the same edge.
- ACK_LOW: on scl_rise -> ACK_HIGH; hold sda_drive_low.
- ACK_HIGH: on scl_fall, release SDA (sda_drive_low<=0) and -> DONE.
- DONE: byte_done=1 for 1 cycle; ack_sent <= latched flag; -> IDLE.
- busy=1 in every state except IDLE. bit_cnt holds its final value in IDLE until the next CLEAR.
- Abort: abort=1 or enable=0 in any non-IDLE state forces IDLE on the next edge. sda_drive_low<=0, sipo_load/sipo_clear<=0, no byte_done; bit_cnt holds. Abort has priority over scl edges and start_rx in the same cycle.
- Edge ordering: a simultaneous scl_rise and start_rx in IDLE does not shift; first bit is the next scl_rise after CLEAR.
- SDA changes while SCL is high are ignored; only the sample at scl_rise matters.
- No timeout; a stalled SCL holds the state indefinitely.

Test Plan:
- Reset: hold rst_=0 with scl_in/sda_in toggling -> all outputs 0, busy=0. Release: no strobes until start_rx.
- Byte 0xA5 MSB-first, ack_en=1, SCL period 20 clk -> 1 sipo_clear pulse; 8 sipo_load pulses, sipo_bit=1,0,1,0,0,1,0,1; each pulse 3 clk after the scl_in rise. sda_drive_low high from the 8th SCL fall to the 9th SCL fall. byte_done=1 for 1 cycle; ack_sent=1; bit_cnt=8.
- Byte 0x3C with ack_en=0 -> loads 0,0,1,1,1,1,0,0; sda_drive_low never asserts; byte_done pulse; ack_sent=0.
- Abort after 4th load -> next cycle busy=0, sda_drive_low=0, no byte_done, bit_cnt=4. Following start_rx gives a clean 8-bit byte.
- start_rx pulsed during SHIFT and enable dropped in ACK_LOW -> start_rx ignored (single sipo_clear). enable drop releases SDA within 1 cycle, no byte_done.
- rst_ asserted asynchronously mid-ACK_LOW -> sda_drive_low falls without a clk edge; state IDLE after release.
